seg_scan_ctrl: RTL

//  Scan controller for the 8-digit common-anode 7-segment display on the 125 MHz core clock.

---
 rtl/seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan controller for an 8-digit common-anode 7-segment display.
//   Display updates arrive over a valid/ready handshake into a shadow buffer.
//   The shadow buffer is copied to the active (displayed) buffer only on the
//   last cycle of digit 7's slot, so a frame never mixes old and new data.
//   Each digit slot starts with a dead band (all anodes off) to suppress
//   ghosting. Every display output comes straight from a flop.
//
// Parameters
//   DIGIT_CYCLES  clocks per digit slot, dead band included (>= DEAD_CYCLES+2)
//   DEAD_CYCLES   clocks at the start of each slot with all anodes off (>= 1)
//
// Ports
//   clk         in   core clock
//   resetn      in   synchronous, active-low reset
//   upd_valid   in   update request
//   upd_ready   out  shadow buffer free
//   upd_digits  in   [31:0] nibble i = hex value of digit i
//   upd_dp      in   [7:0]  bit i = decimal point of digit i lit
//   upd_blank   in   [7:0]  bit i = digit i blanked
//   bright      in   [2:0]  brightness 0..7 (used only with SEG_PWM_EN)
//   seg_n       out  [6:0]  {g,f,e,d,c,b,a}, active low
//   dp_n        out  decimal point, active low
//   an_n        out  [7:0]  anode select, active low, one-hot-low or all high
//   frame_tick  out  1-cycle pulse in the cycle after each commit cycle
//
// Configuration
//   SEG_PWM_EN  when defined, a free-running 3-bit phase gates the anode so
//               the ON duty is (bright+1)/8. When undefined, bright is ignored.

module seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 16384,
    parameter int DEAD_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_digits,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  upd_blank,
    input  logic [2:0]  bright,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        frame_tick
);

    localparam int              CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] slot_cnt;
    logic [2:0]       digit_idx;
    logic             slot_wrap;
    logic             commit;

    logic [31:0]      shadow_digits;
    logic [7:0]       shadow_dp;
    logic [7:0]       shadow_blank;
    logic [31:0]      active_digits;
    logic [7:0]       active_dp;
    logic [7:0]       active_blank;
    logic             pending;
    logic             pending_nxt;
    logic             xfer;

    logic [7:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       cur_nib;

    // Hex to segment pattern, bit order {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------
    assign slot_wrap = (slot_cnt == LAST_CNT);
    // Last cycle of digit 7's slot: the only place the active buffer changes.
    assign commit    = slot_wrap && (digit_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: DEAD for counts 0..DEAD_CYCLES-1, ON for the remainder
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_DEAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DEAD: if (slot_cnt == DEAD_LAST) state_nxt = ST_ON;
            ST_ON:   if (slot_wrap)             state_nxt = ST_DEAD;
            default: state_nxt = ST_DEAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Update handshake and buffers
    //   A transfer happens on a clock edge where upd_valid and upd_ready are
    //   both high. upd_valid may stay high while upd_ready is low; nothing is
    //   taken until upd_ready returns. upd_ready is low exactly while an
    //   update waits in the shadow buffer for the next commit, so at most one
    //   update is ever queued. A commit always copies the shadow as it was
    //   before the edge; an update taken on the commit cycle itself (possible
    //   only when nothing was pending) stays pending for the next frame.
    // ------------------------------------------------------------------
    assign xfer = upd_valid && upd_ready;

    always_comb begin
        pending_nxt = pending;
        if (xfer) begin
            pending_nxt = 1'b1;
        end else if (commit) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_digits <= 32'h0;
            shadow_dp     <= 8'h00;
            shadow_blank  <= 8'hFF;
            active_digits <= 32'h0;
            active_dp     <= 8'h00;
            active_blank  <= 8'hFF;
            pending       <= 1'b0;
            upd_ready     <= 1'b1;
        end else begin
            if (commit && pending) begin
                active_digits <= shadow_digits;
                active_dp     <= shadow_dp;
                active_blank  <= shadow_blank;
            end
            if (xfer) begin
                shadow_digits <= upd_digits;
                shadow_dp     <= upd_dp;
                shadow_blank  <= upd_blank;
            end
            pending   <= pending_nxt;
            upd_ready <= ~pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Brightness gating
    // ------------------------------------------------------------------
`ifdef SEG_PWM_EN
    logic [2:0] pwm_phase;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pwm_phase <= 3'd0;
        end else begin
            pwm_phase <= pwm_phase + 3'd1;
        end
    end
`else
    logic unused_bright;
    assign unused_bright = ^bright;
`endif

    // ------------------------------------------------------------------
    // Output decode (registered below)
    // ------------------------------------------------------------------
    assign cur_nib = active_digits[{digit_idx, 2'b00} +: 4];

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state == ST_ON && !active_blank[digit_idx]) begin
            an_d  = ~(8'h01 << digit_idx);
            seg_d = ~seg_decode(cur_nib);
            dp_d  = ~active_dp[digit_idx];
`ifdef SEG_PWM_EN
            // Anode on only while phase < bright+1; segments stay valid so
            // the gated digit never shows another digit's pattern.
            if (pwm_phase > bright) begin
                an_d = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_n       <= 8'hFF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_d;
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            frame_tick <= commit;
        end
    end

endmodule
